// File: rtl/ethpipe_pkg.sv
// rtl/ethpipe_pkg.sv - shared Ethernet constants, CRC helpers and TX-slot FSM encoding
package ethpipe_pkg;

  localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
  localparam logic [7:0]  ETH_SFD      = 8'hD5;
  localparam logic [31:0] CRC32_POLY   = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;
  localparam int          ETH_MIN_LEN  = 60;
  localparam int          ETH_MAX_LEN  = 1514;
  localparam int          LEN_W        = 11;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_FETCH   = 4'd1,
    ST_CHECK   = 4'd2,
    ST_PRE     = 4'd3,
    ST_SFD     = 4'd4,
    ST_DATA    = 4'd5,
    ST_PAD     = 4'd6,
    ST_FCS     = 4'd7,
    ST_GAP     = 4'd8,
    ST_DONE    = 4'd9,
    ST_WAITCLR = 4'd10
  } tx_state_t;

  // Bit-reverse a 32-bit word; turns the normal polynomial into the LSB-first form.
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/slot_tx_gmii_if.sv
// rtl/slot_tx_gmii_if.sv - slot handshake, RAM port-B and GMII TX signal bundle
interface slot_tx_gmii_if #(
  parameter int ADDR_W = 12
);
  logic              slot_tx_ready;
  logic              slot_tx_complete;
  logic              slot_tx_error;
  logic [ADDR_W-1:0] ram_address;
  logic              ram_rd_en;
  logic [15:0]       ram_q;
  logic [7:0]        gmii_txd;
  logic              gmii_tx_en;
  logic [31:0]       tx_frame_count;

  // master: the transmitter; slave: host status, slot RAM and PHY side
  modport master (
    input  slot_tx_ready, ram_q,
    output slot_tx_complete, slot_tx_error, ram_address, ram_rd_en,
           gmii_txd, gmii_tx_en, tx_frame_count
  );
  modport slave (
    output slot_tx_ready, ram_q,
    input  slot_tx_complete, slot_tx_error, ram_address, ram_rd_en,
           gmii_txd, gmii_tx_en, tx_frame_count
  );
endinterface

// File: rtl/crc32_d8.sv
// rtl/crc32_d8.sv - combinational next-CRC-32 (reflected 802.3) for one data byte
module crc32_d8
  import ethpipe_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_data,
  output logic [31:0] o_crc
);

  localparam logic [31:0] POLY_R = reflect32(CRC32_POLY);

  logic [31:0] w_c;

  // Eight LSB-first shift steps of the reflected CRC register
  always_comb begin
    w_c = i_crc ^ {24'h0, i_data};
    for (int i = 0; i < 8; i++) begin
      w_c = w_c[0] ? ((w_c >> 1) ^ POLY_R) : (w_c >> 1);
    end
  end

  assign o_crc = w_c;

endmodule

// File: rtl/slot_tx_gmii.sv
// rtl/slot_tx_gmii.sv - reads a frame from a TX slot RAM and sends it on GMII with preamble, pad and FCS
module slot_tx_gmii
  import ethpipe_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int MIN_LEN = ETH_MIN_LEN,
  parameter int MAX_LEN = ETH_MAX_LEN,
  parameter int IFG     = 12
) (
  input logic            sys_clk,
  input logic            sys_rst,
  slot_tx_gmii_if.master bus
);

  localparam logic [LEN_W-1:0] MIN_LEN_W = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] MIN_LAST  = LEN_W'(MIN_LEN - 1);
  localparam logic [LEN_W-1:0] MAX_LEN_W = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] IFG_LAST  = LEN_W'(IFG - 1);

  tx_state_t         r_state;
  tx_state_t         w_next;
  logic [LEN_W-1:0]  r_cnt;
  logic [LEN_W-1:0]  r_len;
  logic [ADDR_W-1:0] r_addr;
  logic [15:0]       r_word;
  logic              r_rd_d;
  logic [31:0]       r_crc;
  logic [31:0]       r_count;

  logic [LEN_W-1:0]  w_len;
  logic              w_len_bad;
  logic              w_last_data;
  logic [31:0]       w_fcs;
  logic [31:0]       w_crc_next;
  logic [7:0]        w_txd;
  logic              w_tx_en;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_addr;
  logic              w_complete;
  logic              w_error;

  assign w_len       = bus.ram_q[LEN_W-1:0];
  assign w_len_bad   = (w_len == '0) || (w_len > MAX_LEN_W);
  assign w_last_data = (r_cnt == r_len - LEN_W'(1));
  assign w_fcs       = ~r_crc;

  crc32_d8 u_crc (
    .i_crc  (r_crc),
    .i_data (w_txd),
    .o_crc  (w_crc_next)
  );

  // State register; async reset drops tx_en immediately since outputs decode from state
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // Next state and per-state outputs; address only leaves 0 while a read is issued
  always_comb begin
    w_next     = r_state;
    w_txd      = 8'h00;
    w_tx_en    = 1'b0;
    w_rd_en    = 1'b0;
    w_addr     = '0;
    w_complete = 1'b0;
    w_error    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.slot_tx_ready) w_next = ST_FETCH;
      end
      ST_FETCH: begin
        w_rd_en = 1'b1;
        w_next  = ST_CHECK;
      end
      ST_CHECK: begin
        if (w_len_bad) begin
          w_complete = 1'b1;
          w_error    = 1'b1;
          w_next     = ST_WAITCLR;
        end else begin
          w_rd_en = 1'b1;
          w_addr  = ADDR_W'(1);
          w_next  = ST_PRE;
        end
      end
      ST_PRE: begin
        w_tx_en = 1'b1;
        w_txd   = ETH_PREAMBLE;
        if (r_cnt == LEN_W'(6)) w_next = ST_SFD;
      end
      ST_SFD: begin
        w_tx_en = 1'b1;
        w_txd   = ETH_SFD;
        w_next  = ST_DATA;
      end
      ST_DATA: begin
        w_tx_en = 1'b1;
        w_txd   = r_cnt[0] ? r_word[7:0] : r_word[15:8];
        // On a high byte, fetch the word after the current one if the frame still needs it
        if (!r_cnt[0] && (r_cnt + LEN_W'(2) < r_len)) begin
          w_rd_en = 1'b1;
          w_addr  = r_addr;
        end
        if (w_last_data) w_next = (r_len < MIN_LEN_W) ? ST_PAD : ST_FCS;
      end
      ST_PAD: begin
        w_tx_en = 1'b1;
        if (r_cnt == MIN_LAST) w_next = ST_FCS;
      end
      ST_FCS: begin
        w_tx_en = 1'b1;
        case (r_cnt[1:0])
          2'd0:    w_txd = w_fcs[7:0];
          2'd1:    w_txd = w_fcs[15:8];
          2'd2:    w_txd = w_fcs[23:16];
          default: w_txd = w_fcs[31:24];
        endcase
        if (r_cnt[1:0] == 2'd3) w_next = ST_GAP;
      end
      ST_GAP: begin
        if (r_cnt == IFG_LAST) w_next = ST_DONE;
      end
      ST_DONE: begin
        w_complete = 1'b1;
        w_next     = ST_WAITCLR;
      end
      ST_WAITCLR: begin
        if (!bus.slot_tx_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Phase counter, length latch, word prefetch, running CRC and frame counter
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_cnt   <= '0;
      r_len   <= '0;
      r_addr  <= '0;
      r_word  <= '0;
      r_rd_d  <= 1'b0;
      r_crc   <= CRC32_INIT;
      r_count <= '0;
    end else begin
      // The byte counter runs on from DATA into PAD so PAD ends at MIN_LEN bytes total
      if ((w_next != r_state) && !(r_state == ST_DATA && w_next == ST_PAD)) r_cnt <= '0;
      else                                                                  r_cnt <= r_cnt + LEN_W'(1);
      r_rd_d <= w_rd_en;
      if (r_rd_d) r_word <= bus.ram_q;
      if (r_state == ST_CHECK) begin
        r_len  <= w_len;
        r_addr <= ADDR_W'(2);
        r_crc  <= CRC32_INIT;
      end
      if (r_state == ST_DATA && w_rd_en) r_addr <= r_addr + ADDR_W'(1);
      if (r_state == ST_DATA || r_state == ST_PAD) r_crc <= w_crc_next;
      if (r_state == ST_DONE) r_count <= r_count + 32'd1;
    end
  end

  assign bus.gmii_txd         = w_txd;
  assign bus.gmii_tx_en       = w_tx_en;
  assign bus.ram_rd_en        = w_rd_en;
  assign bus.ram_address      = w_addr;
  assign bus.slot_tx_complete = w_complete;
  assign bus.slot_tx_error    = w_error;
  assign bus.tx_frame_count   = r_count;

endmodule

// File: tb/tb_slot_tx_gmii.sv
// tb/tb_slot_tx_gmii.sv - self-checking bench for slot_tx_gmii
module tb_slot_tx_gmii;

  localparam int IFG   = 12;
  localparam int LIMIT = 1700;

  logic sys_clk;
  logic sys_rst;

  slot_tx_gmii_if #(.ADDR_W(12)) bus ();

  slot_tx_gmii #(.ADDR_W(12), .MIN_LEN(60), .MAX_LEN(1514), .IFG(IFG)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  logic [15:0] mem [0:4095];

  always @(posedge sys_clk) begin
    if (bus.ram_rd_en) bus.ram_q <= mem[bus.ram_address];
  end

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  logic [7:0] frame_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic [15:0] word0;
    bit          ok;
    int          txc;
    int          maxa;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d (0x%0h) expected=%0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Bit-serial 802.3 CRC: MSB-first register fed with each byte LSB first
  function automatic logic [31:0] fcs_model(input logic [7:0] q[$]);
    logic [31:0] c;
    logic [31:0] r;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[31] ^ q[i][b];
        c  = {c[30:0], 1'b0};
        if (fb) c = c ^ 32'h04C11DB7;
      end
    end
    for (int i = 0; i < 32; i++) r[i] = c[31-i];
    return ~r;
  endfunction

  task automatic prep_frame(input logic [15:0] word0);
    int L;
    logic [7:0] body[$];
    logic [31:0] fcs;
    L = int'(word0[10:0]);
    mem[0] = word0;
    frame_q.delete();
    exp_q.delete();
    if (L >= 1 && L <= 1514) begin
      for (int i = 0; i < L; i++) frame_q.push_back(8'($urandom));
      for (int k = 0; k < (L + 1) / 2; k++) begin
        mem[k+1][15:8] = frame_q[2*k];
        mem[k+1][7:0]  = (2*k + 1 < L) ? frame_q[2*k+1] : 8'($urandom);
      end
      body = frame_q;
      while (body.size() < 60) body.push_back(8'h00);
      for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      foreach (body[i]) exp_q.push_back(body[i]);
      fcs = fcs_model(body);
      for (int i = 0; i < 4; i++) exp_q.push_back(fcs[8*i +: 8]);
    end
  endtask

  // Sample one frame from C1 onward; ready (or reset release) was applied in C0
  task automatic capture(input int L, input bit ok, input int txc, input int maxa, input string nm);
    int first_en, last_en, cplt_k, nseg, max_a, rd_bad, idle_bad, bad_i, n;
    bit err, seen;
    logic [7:0] got_q[$];
    first_en = -1; last_en = -1; cplt_k = -1; nseg = 0; max_a = -1;
    rd_bad = 0; idle_bad = 0; err = 1'b0;
    for (int k = 1; k <= LIMIT; k++) begin
      @(negedge sys_clk);
      if (bus.gmii_tx_en) begin
        if (first_en < 0) first_en = k;
        if (last_en >= 0 && last_en != k - 1) nseg++;
        last_en = k;
        got_q.push_back(bus.gmii_txd);
      end else if (bus.gmii_txd != 8'h00) begin
        idle_bad++;
      end
      if (bus.ram_rd_en) begin
        if (int'(bus.ram_address) > max_a) max_a = int'(bus.ram_address);
        if (k > 2 && !(k >= 11 && k < 11 + L)) rd_bad++;
      end
      if (bus.slot_tx_complete) begin
        cplt_k = k;
        err    = bus.slot_tx_error;
        break;
      end
    end
    check({nm, "_complete_cycle"}, cplt_k, ok ? 3 + txc + IFG : 2);
    check({nm, "_error"}, err, !ok);
    check({nm, "_txen_rise"}, first_en, ok ? 3 : -1);
    check({nm, "_txen_cycles"}, got_q.size(), txc);
    check({nm, "_txen_gaps"}, nseg, 0);
    check({nm, "_max_addr"}, max_a, maxa);
    check({nm, "_rd_outside"}, rd_bad, 0);
    check({nm, "_idle_txd"}, idle_bad, 0);
    if (ok) begin
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      bad_i = 0;
      for (int i = 0; i < n; i++) begin
        if (got_q[i] !== exp_q[i]) begin
          bad_i = i;
          break;
        end
      end
      if (n > 0) check({nm, "_stream_byte"}, got_q[bad_i], exp_q[bad_i]);
      exp_count++;
    end
    @(negedge sys_clk);
    check({nm, "_count"}, bus.tx_frame_count, exp_count);
    seen = 1'b0;
    repeat (20) begin
      @(negedge sys_clk);
      if (bus.gmii_tx_en || bus.slot_tx_complete) seen = 1'b1;
    end
    check({nm, "_no_resend"}, seen, 0);
    bus.slot_tx_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    prep_frame(v.word0);
    @(negedge sys_clk);
    bus.slot_tx_ready = 1'b1;
    capture(int'(v.word0[10:0]), v.ok, v.txc, v.maxa, nm);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t rv;
    int L;
    vecs[0]  = '{16'd64,   1'b1, 76,   32};
    vecs[1]  = '{16'd20,   1'b1, 72,   10};
    vecs[2]  = '{16'd61,   1'b1, 73,   31};
    vecs[3]  = '{16'd0,    1'b0, 0,    0};
    vecs[4]  = '{16'd1515, 1'b0, 0,    0};
    vecs[5]  = '{16'd1,    1'b1, 72,   1};
    vecs[6]  = '{16'd60,   1'b1, 72,   30};
    vecs[7]  = '{16'd59,   1'b1, 72,   30};
    vecs[8]  = '{16'hF840, 1'b1, 76,   32};
    vecs[9]  = '{16'd1514, 1'b1, 1526, 757};
    vecs[10] = '{16'h07FF, 1'b0, 0,    0};
    vecs[11] = '{16'h0800, 1'b0, 0,    0};

    sys_rst = 1'b1;
    bus.slot_tx_ready = 1'b0;
    #23;
    check("reset_tx_en", bus.gmii_tx_en, 0);
    check("reset_txd", bus.gmii_txd, 0);
    check("reset_complete", bus.slot_tx_complete, 0);
    check("reset_error", bus.slot_tx_error, 0);
    check("reset_rd_en", bus.ram_rd_en, 0);
    check("reset_addr", bus.ram_address, 0);
    check("reset_count", bus.tx_frame_count, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d_len%0d", i, vecs[i].word0[10:0]));

    for (int r = 0; r < 6; r++) begin
      L = (r == 5) ? int'($urandom_range(200, 1514)) : int'($urandom_range(1, 200));
      rv.word0 = {5'($urandom), 11'(L)};
      rv.ok    = 1'b1;
      rv.txc   = 12 + ((L > 60) ? L : 60);
      rv.maxa  = (L + 1) / 2;
      run_vec(rv, $sformatf("rnd%0d_len%0d", r, L));
    end
    for (int r = 0; r < 2; r++) begin
      L = int'($urandom_range(1515, 2047));
      rv = '{{5'($urandom), 11'(L)}, 1'b0, 0, 0};
      run_vec(rv, $sformatf("rndrej%0d_len%0d", r, L));
    end

    prep_frame(16'd100);
    @(negedge sys_clk);
    bus.slot_tx_ready = 1'b1;
    repeat (41) @(negedge sys_clk);
    check("rst_mid_txen_before", bus.gmii_tx_en, 1);
    check("rst_mid_byte30", bus.gmii_txd, exp_q[38]);
    #2 sys_rst = 1'b1;
    #1;
    check("rst_mid_txen", bus.gmii_tx_en, 0);
    check("rst_mid_txd", bus.gmii_txd, 0);
    check("rst_mid_count", bus.tx_frame_count, 0);
    exp_count = 0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    capture(100, 1'b1, 112, 50, "rst_resend");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
